// File: rtl/cpu_pkg.sv
// Shared decode definitions for the Hack-style CPU core: C-instruction field
// positions, jump encodings and the decoded control bundle.
package cpu_pkg;

  localparam int C_A_BIT    = 12;
  localparam int C_CTRL_LSB = 6;
  localparam int C_D_LSB    = 3;
  localparam int C_J_LSB    = 0;

  localparam logic [2:0] JGT = 3'b001;
  localparam logic [2:0] JEQ = 3'b010;
  localparam logic [2:0] JGE = 3'b011;
  localparam logic [2:0] JLT = 3'b100;
  localparam logic [2:0] JNE = 3'b101;
  localparam logic [2:0] JLE = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  typedef struct packed {
    logic       is_c;
    logic       a;
    logic       zx, nx, zy, ny, f, no;
    logic       d_a, d_d, d_m;
    logic [2:0] jmp;
  } ctrl_t;

  // Decodes the low 13 bits shared by every DATA_W; upper bits are don't-care.
  function automatic ctrl_t decode_c(input logic msb, input logic [12:0] fld);
    ctrl_t c;
    c.is_c                         = msb;
    c.a                            = fld[C_A_BIT];
    {c.zx, c.nx, c.zy, c.ny, c.f, c.no} = fld[C_CTRL_LSB +: 6];
    {c.d_a, c.d_d, c.d_m}          = fld[C_D_LSB +: 3];
    c.jmp                          = fld[C_J_LSB +: 3];
    return c;
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: zero/negate each operand, add or AND, optionally negate the result.
module hack_alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [DATA_W-1:0] out,
  output logic              z,
  output logic              n
);

  logic [DATA_W-1:0] xa, ya, r;

  always_comb begin
    xa = zx ? '0 : x;
    xa = nx ? ~xa : xa;
    ya = zy ? '0 : y;
    ya = ny ? ~ya : ya;
    r  = f ? (xa + ya) : (xa & ya);
    r  = no ? ~r : r;
  end

  assign out = r;
  assign z   = (r == '0);
  assign n   = r[DATA_W-1];

endmodule

// File: rtl/hack_cpu_stall.sv
// Parametrised Hack CPU core with memory-ready stall, instruction-valid
// qualifier, self-jump halt detection and a retired-instruction counter.
module hack_cpu_stall
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reset,
  input  logic [DATA_W-1:0] inM,
  input  logic [DATA_W-1:0] instruction,
  input  logic              instr_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc,
  output logic              z,
  output logic              n,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  logic [DATA_W-1:0] a_q, a_d, d_q, d_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  ctrl_t             dec;
  logic [DATA_W-1:0] alu_out;
  logic              alu_z, alu_n;
  logic              cond, jump, stall, retire, self_jmp;

  assign dec = decode_c(instruction[DATA_W-1], instruction[12:0]);

  hack_alu #(.DATA_W(DATA_W)) u_alu (
    .x  (d_q),
    .y  (dec.a ? inM : a_q),
    .zx (dec.zx),
    .nx (dec.nx),
    .zy (dec.zy),
    .ny (dec.ny),
    .f  (dec.f),
    .no (dec.no),
    .out(alu_out),
    .z  (alu_z),
    .n  (alu_n)
  );

  always_comb begin
    cond = 1'b0;
    unique case (dec.jmp)
      JGT:     cond = ~alu_n & ~alu_z;
      JEQ:     cond = alu_z;
      JGE:     cond = ~alu_n;
      JLT:     cond = alu_n;
      JNE:     cond = ~alu_z;
      JLE:     cond = alu_n | alu_z;
      JMP:     cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  // Any C-instruction touching M (read via a, or write via d3) waits for memory.
  assign jump     = dec.is_c & cond;
  assign stall    = instr_valid & dec.is_c & (dec.a | dec.d_m) & ~mem_ready;
  assign retire   = instr_valid & ~stall & ~halted_q;
  assign self_jmp = jump & (a_q[ADDR_W-1:0] == pc_q);

  always_comb begin
    a_d       = a_q;
    d_d       = d_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    if (retire) begin
      if (!dec.is_c) begin
        a_d = {1'b0, instruction[DATA_W-2:0]};
      end else begin
        if (dec.d_a) a_d = alu_out;
        if (dec.d_d) d_d = alu_out;
      end
      if (jump) begin
        pc_d = a_q[ADDR_W-1:0];
        if (self_jmp) halted_d = 1'b1;
      end else begin
        pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    // Program reset wins over jump/halt but still lets A/D load.
    if (reset) begin
      pc_d      = '0;
      halted_d  = 1'b0;
      retired_d = retired_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      d_q       <= '0;
      pc_q      <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      a_q       <= a_d;
      d_q       <= d_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign outM     = alu_out;
  assign z        = alu_z;
  assign n        = alu_n;
  assign writeM   = instr_valid & dec.is_c & dec.d_m & ~halted_q;
  assign addressM = a_q[ADDR_W-1:0];
  assign pc       = pc_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_hack_cpu_stall.sv
// Bench for hack_cpu_stall: directed vector table, hand-written corner cases,
// a 24-bit instance and randomized stimulus against a mnemonic-level model.
module tb_hack_cpu_stall;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        rst_n16, reset16, iv16, mr16;
  logic [15:0] inM16, ins16, outM16;
  logic        wm16, z16, n16, halt16;
  logic [14:0] addr16, pc16;
  logic [31:0] ret16;

  hack_cpu_stall dut16 (
    .clk(clk), .rst_n(rst_n16), .reset(reset16), .inM(inM16), .instruction(ins16),
    .instr_valid(iv16), .mem_ready(mr16), .outM(outM16), .writeM(wm16),
    .addressM(addr16), .pc(pc16), .z(z16), .n(n16), .halted(halt16), .retired(ret16)
  );

  // 24-bit instance
  logic        rst_n24, reset24, iv24, mr24;
  logic [23:0] inM24, ins24, outM24;
  logic        wm24, z24, n24, halt24;
  logic [19:0] addr24, pc24;
  logic [31:0] ret24;

  hack_cpu_stall #(.DATA_W(24), .ADDR_W(20), .CNT_W(32)) dut24 (
    .clk(clk), .rst_n(rst_n24), .reset(reset24), .inM(inM24), .instruction(ins24),
    .instr_valid(iv24), .mem_ready(mr24), .outM(outM24), .writeM(wm24),
    .addressM(addr24), .pc(pc24), .z(z24), .n(n24), .halted(halt24), .retired(ret24)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive16(input logic [15:0] ins, input logic iv, input logic mr,
                         input logic rs, input logic [15:0] im);
    ins16 = ins; iv16 = iv; mr16 = mr; reset16 = rs; inM16 = im;
    #2;
  endtask

  task automatic drive24(input logic [23:0] ins);
    ins24 = ins; iv24 = 1'b1; mr24 = 1'b1; reset24 = 1'b0; inM24 = '0;
    #2;
  endtask

  typedef struct {
    logic [15:0] ins;
    logic        iv, mr, rs;
    logic [14:0] pc;
    logic [31:0] ret;
    logic        wm, hlt, co;
    logic [15:0] out;
    logic        z, n;
  } vec_t;

  vec_t tbl[24];

  // Standard Hack comp codes (zx nx zy ny f no), evaluated by mnemonic below.
  logic [5:0] comps[18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                            6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                            6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                            6'b000111, 6'b000000, 6'b010101};

  function automatic logic [15:0] comp_ref(input int k, input logic [15:0] x, input logic [15:0] y);
    case (k)
      0:  return 16'd0;
      1:  return 16'd1;
      2:  return 16'hFFFF;
      3:  return x;
      4:  return y;
      5:  return ~x;
      6:  return ~y;
      7:  return 16'd0 - x;
      8:  return 16'd0 - y;
      9:  return x + 16'd1;
      10: return y + 16'd1;
      11: return x - 16'd1;
      12: return y - 16'd1;
      13: return x + y;
      14: return x - y;
      15: return y - x;
      16: return x & y;
      default: return x | y;
    endcase
  endfunction

  // Model state
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic        m_halt;
  logic [31:0] m_ret;

  initial begin
    rst_n16 = 1'b1; rst_n24 = 1'b1;
    reset16 = 1'b0; iv16 = 1'b0; mr16 = 1'b1; inM16 = '0; ins16 = '0;
    reset24 = 1'b0; iv24 = 1'b0; mr24 = 1'b1; inM24 = '0; ins24 = '0;

    //            ins       iv mr rs pc  ret wm hlt co out       z  n
    tbl[0]  = '{16'h0005, H, H, L, 15'd0,  32'd0,  L, L, L, 16'h0000, L, L};
    tbl[1]  = '{16'hEC10, H, H, L, 15'd1,  32'd1,  L, L, H, 16'h0005, L, L};
    tbl[2]  = '{16'h0007, H, H, L, 15'd2,  32'd2,  L, L, L, 16'h0000, L, L};
    tbl[3]  = '{16'hE090, H, H, L, 15'd3,  32'd3,  L, L, H, 16'h000C, L, L};
    tbl[4]  = '{16'h0000, H, H, L, 15'd4,  32'd4,  L, L, L, 16'h0000, L, L};
    tbl[5]  = '{16'hE308, H, H, L, 15'd5,  32'd5,  H, L, H, 16'h000C, L, L};
    tbl[6]  = '{16'h000A, H, H, L, 15'd6,  32'd6,  L, L, L, 16'h0000, L, L};
    tbl[7]  = '{16'hE301, H, H, L, 15'd7,  32'd7,  L, L, H, 16'h000C, L, L};
    tbl[8]  = '{16'hE302, H, H, L, 15'd10, 32'd8,  L, L, H, 16'h000C, L, L};
    tbl[9]  = '{16'hE308, H, L, L, 15'd11, 32'd9,  H, L, H, 16'h000C, L, L};
    tbl[10] = '{16'hE308, H, L, L, 15'd11, 32'd9,  H, L, H, 16'h000C, L, L};
    tbl[11] = '{16'hE308, H, L, L, 15'd11, 32'd9,  H, L, H, 16'h000C, L, L};
    tbl[12] = '{16'hE308, H, H, L, 15'd11, 32'd9,  H, L, H, 16'h000C, L, L};
    tbl[13] = '{16'h0004, H, H, H, 15'd12, 32'd10, L, L, L, 16'h0000, L, L};
    tbl[14] = '{16'h0004, H, H, L, 15'd0,  32'd10, L, L, L, 16'h0000, L, L};
    tbl[15] = '{16'h0004, H, H, L, 15'd1,  32'd11, L, L, L, 16'h0000, L, L};
    tbl[16] = '{16'h0004, H, H, L, 15'd2,  32'd12, L, L, L, 16'h0000, L, L};
    tbl[17] = '{16'h0004, H, H, L, 15'd3,  32'd13, L, L, L, 16'h0000, L, L};
    tbl[18] = '{16'hEA87, H, H, L, 15'd4,  32'd14, L, L, H, 16'h0000, H, L};
    tbl[19] = '{16'hE308, H, H, L, 15'd4,  32'd15, L, H, H, 16'h000C, L, L};
    tbl[20] = '{16'hE308, H, H, H, 15'd4,  32'd15, L, H, H, 16'h000C, L, L};
    tbl[21] = '{16'h0000, L, H, L, 15'd0,  32'd15, L, L, L, 16'h0000, L, L};
    tbl[22] = '{16'hE308, L, H, L, 15'd0,  32'd15, L, L, H, 16'h000C, L, L};
    tbl[23] = '{16'h0009, H, H, L, 15'd0,  32'd15, L, L, L, 16'h0000, L, L};

    // Power-on reset
    #1 rst_n16 = 1'b0; rst_n24 = 1'b0;
    #2;
    chk("rst_pc", pc16, 0);
    chk("rst_addr", addr16, 0);
    chk("rst_retired", ret16, 0);
    chk("rst_halted", halt16, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n16 = 1'b1; rst_n24 = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive16(tbl[i].ins, tbl[i].iv, tbl[i].mr, tbl[i].rs, 16'h0000);
      chk($sformatf("row%0d_pc", i), pc16, tbl[i].pc);
      chk($sformatf("row%0d_retired", i), ret16, tbl[i].ret);
      chk($sformatf("row%0d_writeM", i), wm16, tbl[i].wm);
      chk($sformatf("row%0d_halted", i), halt16, tbl[i].hlt);
      if (tbl[i].co) begin
        chk($sformatf("row%0d_outM", i), outM16, tbl[i].out);
        chk($sformatf("row%0d_z", i), z16, tbl[i].z);
        chk($sformatf("row%0d_n", i), n16, tbl[i].n);
      end
      if (i == 5) chk("row5_addressM", addr16, 0);
      tick();
    end

    // Stall then async reset mid-cycle: state clears without a clock edge.
    drive16(16'hE308, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("stall_writeM", wm16, 1);
    chk("stall_addr", addr16, 15'd9);
    chk("stall_pc", pc16, 15'd1);
    tick();
    chk("stall_pc_hold", pc16, 15'd1);
    chk("stall_ret_hold", ret16, 32'd16);
    #1 rst_n16 = 1'b0;
    #1;
    chk("async_pc", pc16, 0);
    chk("async_addr", addr16, 0);
    chk("async_retired", ret16, 0);
    tick();
    chk("async_pc_held", pc16, 0);
    rst_n16 = 1'b1;

    // 24-bit instance
    drive24(24'h800E90);
    chk("w24_outM_m1", outM24, 24'hFFFFFF);
    chk("w24_n", n24, 1);
    chk("w24_writeM", wm24, 0);
    tick();
    drive24(24'h800300);
    chk("w24_D", outM24, 24'hFFFFFF);
    chk("w24_z", z24, 0);
    tick();
    drive24(24'h7FFFFF);
    tick();
    drive24(24'h800A87);
    chk("w24_addr", addr24, 20'hFFFFF);
    chk("w24_pc3", pc24, 20'd3);
    tick();
    drive24(24'h000000);
    chk("w24_pc_top", pc24, 20'hFFFFF);
    chk("w24_halted", halt24, 0);
    tick();
    iv24 = 1'b0;
    #2;
    chk("w24_pc_wrap", pc24, 20'd0);
    chk("w24_retired", ret24, 32'd5);

    // Randomized run against the mnemonic-level model
    rst_n16 = 1'b0;
    #1 rst_n16 = 1'b1;
    m_a = '0; m_d = '0; m_pc = '0; m_halt = 1'b0; m_ret = '0;
    for (int it = 0; it < 600; it++) begin
      logic [15:0] ins, im, out, old_a;
      logic        iv, mr, rs, isc, a, zz, nn, jump, stall, ret;
      logic [2:0]  d, j;
      int          k;
      k  = int'($urandom_range(0, 17));
      a  = 1'($urandom_range(0, 1));
      d  = 3'($urandom_range(0, 7));
      j  = 3'($urandom_range(0, 7));
      im = 16'($urandom);
      if ($urandom_range(0, 2) == 0) ins = {1'b0, 15'($urandom)};
      else ins = {3'b111, a, comps[k], d, j};
      iv = ($urandom_range(0, 7) != 0);
      mr = ($urandom_range(0, 3) != 0);
      rs = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      drive16(ins, iv, mr, rs, im);

      isc = ins[15];
      out = comp_ref(k, m_d, a ? im : m_a);
      zz  = (out == 16'd0);
      nn  = out[15];
      chk($sformatf("rnd%0d_pc", it), pc16, m_pc);
      chk($sformatf("rnd%0d_addr", it), addr16, m_a[14:0]);
      chk($sformatf("rnd%0d_halted", it), halt16, m_halt);
      chk($sformatf("rnd%0d_retired", it), ret16, m_ret);
      chk($sformatf("rnd%0d_writeM", it), wm16, iv & isc & d[0] & ~m_halt);
      if (isc) begin
        chk($sformatf("rnd%0d_outM", it), outM16, out);
        chk($sformatf("rnd%0d_zn", it), {z16, n16}, {zz, nn});
      end

      jump  = isc & ((j[2] & nn) | (j[1] & zz) | (j[0] & ~nn & ~zz));
      stall = iv & isc & (a | d[0]) & ~mr;
      ret   = iv & ~stall & ~m_halt;
      old_a = m_a;
      if (ret) begin
        if (!isc) m_a = {1'b0, ins[14:0]};
        else begin
          if (d[2]) m_a = out;
          if (d[1]) m_d = out;
        end
      end
      if (rs) begin
        m_pc = '0; m_halt = 1'b0;
      end else if (ret) begin
        if (jump) begin
          if (old_a[14:0] == m_pc) m_halt = 1'b1;
          else m_pc = old_a[14:0];
        end else m_pc = m_pc + 15'd1;
      end
      if (ret && !rs) m_ret = m_ret + 32'd1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
